gate_sweeper: RTL and testbench

Parametrised N-input configurable logic gate with a built-in exhaustive sweep engine. On a start pulse it applies every input combination 0..2^N-1 to the selected gate function, holding each vector a programmable number of cycles, and assembles the gate's full truth table. The block sits in the lab-exercise designs as the sequential successor to the two-input combinational gate. When no sweep is running, it acts as a registered live gate on external inputs.

---
 rtl/gate_sweeper_if.sv | 32 +++
 rtl/gate_sweeper.sv | 124 ++++++++++++
 tb/tb_gate_sweeper.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweeper_if.sv
// gate_sweeper_if: handshake/data bundle between a gate_sweeper and whatever drives it.
//   i_x      live gate inputs (used only while idle)
//   i_mode   gate function select
//   i_start  sweep request
//   o_y      registered gate output
//   o_vec    vector currently applied to the gate
//   o_table  truth table, bit k = f(k)
//   o_busy   high while sweeping
//   o_done   one-cycle pulse at sweep completion
// master: the stimulus side; slave: the gate_sweeper itself.
interface gate_sweeper_if #(
   parameter int unsigned N = 2
);
   logic [N-1:0]        i_x;
   logic [2:0]          i_mode;
   logic                i_start;
   logic                o_y;
   logic [N-1:0]        o_vec;
   logic [(1<<N)-1:0]   o_table;
   logic                o_busy;
   logic                o_done;

   modport master (
      output i_x, i_mode, i_start,
      input  o_y, o_vec, o_table, o_busy, o_done
   );

   modport slave (
      input  i_x, i_mode, i_start,
      output o_y, o_vec, o_table, o_busy, o_done
   );
endinterface

// File: rtl/gate_sweeper.sv
// gate_sweeper: N-input configurable logic gate with an exhaustive sweep engine.
// Idle: registered live gate on bus.i_x. On bus.i_start the mode is latched and every
// vector 0..2^N-1 is applied for HOLD cycles each, building the truth table in o_table.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      gate_sweeper_if slave modport (inputs x/mode/start, outputs y/vec/table/busy/done)
module gate_sweeper #(
   parameter int unsigned N    = 2,
   parameter int unsigned HOLD = 1
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   gate_sweeper_if.slave  bus
);
   localparam int unsigned NumVec   = 1 << N;
   localparam logic [N:0]  LastVec  = (N+1)'(NumVec - 1);
   localparam logic [7:0]  HoldLast = 8'(HOLD - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [N:0]          vec_q, vec_d;
   logic [7:0]          hold_q, hold_d;
   logic [NumVec-1:0]   table_q, table_d;
   logic                y_q, y_d;
   logic                step;
   logic [N-1:0]        vec_lo;
   logic                f_sweep;

   function automatic logic gate_fn(input logic [2:0] mode, input logic [N-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < int'(N); i++) ones += 32'(v[i]);
      case (mode)
         3'd0:    return ones == N;
         3'd1:    return ones != 0;
         3'd2:    return ones[0];
         3'd3:    return ones != N;
         3'd4:    return ones == 0;
         3'd5:    return !ones[0];
         3'd6:    return (2 * ones) > N;   // strict: a tie gives 0
         default: return 1'b0;
      endcase
   endfunction

   // Counter is N+1 bits; after the last vector it reads 2^N, which is clamped on o_vec.
   assign vec_lo  = vec_q[N] ? {N{1'b1}} : vec_q[N-1:0];
   assign step    = (hold_q == HoldLast);
   assign f_sweep = gate_fn(mode_q, vec_lo);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         mode_q  <= '0;
         vec_q   <= '0;
         hold_q  <= '0;
         table_q <= '0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         table_q <= table_d;
         y_q     <= y_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.i_start) state_d = StSweep;
         StSweep: if (step && (vec_q == LastVec)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      mode_d  = mode_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      table_d = table_q;
      y_d     = y_q;
      unique case (state_q)
         StIdle: begin
            y_d = gate_fn(bus.i_mode, bus.i_x);
            if (bus.i_start) begin
               mode_d  = bus.i_mode;
               vec_d   = '0;
               hold_d  = '0;
               table_d = '0;
            end else begin
               vec_d = {1'b0, bus.i_x};
            end
         end
         StSweep: begin
            y_d = f_sweep;
            if (step) begin
               table_d[vec_lo] = f_sweep;
               hold_d          = '0;
               vec_d           = vec_q + 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus.o_busy  = (state_q == StSweep);
      bus.o_done  = (state_q == StDone);
      bus.o_vec   = vec_lo;
      bus.o_y     = y_q;
      bus.o_table = table_q;
   end
endmodule

// File: tb/tb_gate_sweeper.sv
// tb_gate_sweeper: directed bench for gate_sweeper across several N/HOLD instances.
// Expected vectors, outputs and tables are queued when a sweep is launched and popped as
// the DUT produces them.
module tb_gate_sweeper;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance table: 0:(N2,H1) 1:(N2,H10) 2:(N2,H4) 3:(N3,H1) 4:(N4,H1)
   logic [4:0]        start_v = '0;
   logic [4:0][2:0]   mode_v  = '0;
   logic [4:0][3:0]   x_v     = '0;
   logic [4:0]        busy_v, done_v, y_v;
   logic [4:0][3:0]   vec_v;
   logic [4:0][15:0]  tbl_v;

   gate_sweeper_if #(.N(2)) if0 ();
   gate_sweeper_if #(.N(2)) if1 ();
   gate_sweeper_if #(.N(2)) if2 ();
   gate_sweeper_if #(.N(3)) if3 ();
   gate_sweeper_if #(.N(4)) if4 ();

   gate_sweeper #(.N(2), .HOLD(1))  u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
   gate_sweeper #(.N(2), .HOLD(10)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
   gate_sweeper #(.N(2), .HOLD(4))  u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
   gate_sweeper #(.N(3), .HOLD(1))  u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
   gate_sweeper #(.N(4), .HOLD(1))  u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));

   assign if0.i_start = start_v[0];
   assign if1.i_start = start_v[1];
   assign if2.i_start = start_v[2];
   assign if3.i_start = start_v[3];
   assign if4.i_start = start_v[4];
   assign if0.i_mode  = mode_v[0];
   assign if1.i_mode  = mode_v[1];
   assign if2.i_mode  = mode_v[2];
   assign if3.i_mode  = mode_v[3];
   assign if4.i_mode  = mode_v[4];
   assign if0.i_x     = x_v[0][1:0];
   assign if1.i_x     = x_v[1][1:0];
   assign if2.i_x     = x_v[2][1:0];
   assign if3.i_x     = x_v[3][2:0];
   assign if4.i_x     = x_v[4];

   assign busy_v = {if4.o_busy, if3.o_busy, if2.o_busy, if1.o_busy, if0.o_busy};
   assign done_v = {if4.o_done, if3.o_done, if2.o_done, if1.o_done, if0.o_done};
   assign y_v    = {if4.o_y, if3.o_y, if2.o_y, if1.o_y, if0.o_y};
   assign vec_v[0] = 4'(if0.o_vec);
   assign vec_v[1] = 4'(if1.o_vec);
   assign vec_v[2] = 4'(if2.o_vec);
   assign vec_v[3] = 4'(if3.o_vec);
   assign vec_v[4] = if4.o_vec;
   assign tbl_v[0] = 16'(if0.o_table);
   assign tbl_v[1] = 16'(if1.o_table);
   assign tbl_v[2] = 16'(if2.o_table);
   assign tbl_v[3] = 16'(if3.o_table);
   assign tbl_v[4] = if4.o_table;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] sb_vec[$];
   logic [15:0] sb_y[$];
   logic [15:0] sb_tbl[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pop_q(inout logic [15:0] q[$]);
      if (q.size() == 0) return 16'hdead;
      return q.pop_front();
   endfunction

   // Reference gate, written from the function list
   function automatic logic ref_gate(input logic [2:0] mode, input int n, input int v);
      int ones = 0;
      for (int i = 0; i < n; i++) ones += (v >> i) & 1;
      case (mode)
         3'd0:    return ones == n;
         3'd1:    return ones > 0;
         3'd2:    return (ones % 2) == 1;
         3'd3:    return ones != n;
         3'd4:    return ones == 0;
         3'd5:    return (ones % 2) == 0;
         3'd6:    return (2 * ones) > n;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_reset_vals(input int d, input string tag);
      chk({tag, "_busy"},  32'(busy_v[d]), 32'd0);
      chk({tag, "_done"},  32'(done_v[d]), 32'd0);
      chk({tag, "_vec"},   32'(vec_v[d]),  32'd0);
      chk({tag, "_table"}, 32'(tbl_v[d]),  32'd0);
      chk({tag, "_y"},     32'(y_v[d]),    32'd0);
   endtask

   task automatic run_sweep(input int d, input logic [2:0] mode, input int n, input int hold,
                            input logic [15:0] exp_tbl, input bit toggle,
                            input int ign_a, input int ign_b, input string tag);
      int nvec = 1 << n;
      int len  = hold * nvec;
      @(negedge clk);
      mode_v[d]  = mode;
      start_v[d] = 1'b1;
      for (int k = 0; k < nvec; k++)
         for (int h = 0; h < hold; h++) sb_vec.push_back(16'(k));
      for (int c = 1; c <= len; c++) sb_y.push_back(16'(ref_gate(mode, n, (c - 1) / hold)));
      sb_tbl.push_back(exp_tbl);
      @(posedge clk);
      #1 start_v[d] = 1'b0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 32'(busy_v[d]), 32'd1);
         chk({tag, "_done_low"}, 32'(done_v[d]), 32'd0);
         chk({tag, "_vec"}, 32'(vec_v[d]), 32'(pop_q(sb_vec)));
         if (c >= 1) chk({tag, "_y"}, 32'(y_v[d]), 32'(pop_q(sb_y)));
         if (toggle && c == 0) mode_v[d] = 3'd7;
         start_v[d] = (c == ign_a || c == ign_b);
      end
      @(negedge clk);
      start_v[d] = 1'b0;
      chk({tag, "_busy_end"}, 32'(busy_v[d]), 32'd0);
      chk({tag, "_done"}, 32'(done_v[d]), 32'd1);
      chk({tag, "_y_last"}, 32'(y_v[d]), 32'(pop_q(sb_y)));
      chk({tag, "_table"}, 32'(tbl_v[d]), 32'(pop_q(sb_tbl)));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done_v[d]), 32'd0);
      chk({tag, "_idle"}, 32'(busy_v[d]), 32'd0);
      chk({tag, "_table_hold"}, 32'(tbl_v[d]), 32'(exp_tbl));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] nand_exp;
      logic       seen;
      nand_exp = 4'b0111;

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < 5; d++) check_reset_vals(d, "reset");
      rst_n = 1'b1;

      // Basic sweeps, N=2 HOLD=1
      run_sweep(0, 3'd0, 2, 1, 16'h0008, 1'b0, -1, -1, "and");
      run_sweep(0, 3'd2, 2, 1, 16'h0006, 1'b1, -1, -1, "xor");
      run_sweep(0, 3'd4, 2, 1, 16'h0001, 1'b1, -1, -1, "nor");
      run_sweep(0, 3'd5, 2, 1, 16'h0009, 1'b1, -1, -1, "xnor");

      // HOLD=10 with ignored start pulses
      run_sweep(1, 3'd1, 2, 10, 16'h000e, 1'b0, 5, 20, "or_hold");

      // Live NAND in idle
      @(negedge clk);
      mode_v[0] = 3'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         x_v[0] = 4'(i);
         @(negedge clk);
         chk("live_y", 32'(y_v[0]), 32'(nand_exp[i]));
         chk("live_vec", 32'(vec_v[0]), 32'(i));
         chk("live_busy", 32'(busy_v[0]), 32'd0);
         repeat (8) @(negedge clk);
      end
      x_v[0] = '0;

      // Majority, odd and even N
      run_sweep(3, 3'd6, 3, 1, 16'h00e8, 1'b0, -1, -1, "maj3");
      run_sweep(4, 3'd6, 4, 1, 16'he880, 1'b0, -1, -1, "maj4");

      // Start held high: busy 4, done 1, idle 1, then busy again
      @(negedge clk);
      mode_v[0]  = 3'd0;
      start_v[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("b2b_busy", 32'(busy_v[0]), 32'd1);
      end
      @(negedge clk);
      chk("b2b_done", 32'(done_v[0]), 32'd1);
      @(negedge clk);
      chk("b2b_gap_busy", 32'(busy_v[0]), 32'd0);
      chk("b2b_gap_done", 32'(done_v[0]), 32'd0);
      @(negedge clk);
      chk("b2b_restart", 32'(busy_v[0]), 32'd1);
      start_v[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("b2b_settle", 32'(busy_v[0]), 32'd0);

      // Reset in the middle of a HOLD=4 sweep
      @(negedge clk);
      mode_v[2]  = 3'd0;
      start_v[2] = 1'b1;
      @(posedge clk);
      #1 start_v[2] = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_pre_vec", 32'(vec_v[2]), 32'd1);
      chk("rst_pre_busy", 32'(busy_v[2]), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_vals(2, "rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | done_v[2] | busy_v[2];
      end
      chk("rst_no_done", 32'(seen), 32'd0);
      run_sweep(2, 3'd1, 2, 4, 16'h000e, 1'b0, -1, -1, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
